vigna_prefetch: RTL and testbench
=================================

// Module: vigna_prefetch
// PURPOSE
//   Parametrised instruction prefetch unit for the next-generation vigna core.
//   Replaces the single-shot fetch FSM with a DEPTH-entry {pc, inst} FIFO.
//   Issues back-to-back word fetches on the instruction valid/ready bus.
//   Supports redirect (branch/jump) with flush and in-flight response drop.
//   Sits between the i-bus and the core decode/execute stage.
// PARAMETERS
//   RESET_ADDR  32'h0000_0000  first fetch address after reset
//   DEPTH       4              FIFO entries; power of two, >= 2
// PORTS
//   clk             in   1                    clock, all state on posedge
//   reset           in   1                    asynchronous, active-high reset
//   i_valid         out  1                    fetch request valid (registered)
//   i_ready         in   1                    request accepted; i_rdata valid this cycle
//   i_addr          out  32                   fetch address, word aligned
//   i_rdata         in   32                   instruction word
//   inst_valid      out  1                    FIFO head valid
//   inst_ready      in   1                    core consumes head
//   inst            out  32                   head instruction
//   inst_pc         out  32                   head instruction address
//   redirect_valid  in   1                    flush and restart at redirect_addr
//   redirect_addr   in   32                   new pc; bits [1:0] ignored (forced 0)
//   count           out  $clog2(DEPTH+1)      occupied entries
// BEHAVIOUR
//   Reset values (async): i_valid=0, fetch_pc=RESET_ADDR, count=0, drop=0.
//   Reset value of inst_valid is 0.
//   i_addr = fetch_pc.
//   Reset asserted mid-request drops the request: i_valid falls immediately.
//   First request: i_valid=1 on the first clk edge after reset deasserts.
//   Bus rule: once i_valid=1, it stays 1 with i_addr stable until i_ready.
//   Push: i_valid & i_ready & !drop & !redirect_valid writes {fetch_pc, i_rdata}.
//   Push latency: the word is visible at the FIFO head one cycle later at the earliest.
//   On handshake: fetch_pc += 4 (wraps mod 2^32).
//     i_valid stays 1 iff count_next < DEPTH, else 0.
//     count_next = count + push - pop.
//   While i_valid=0 and no redirect, i_valid rises when count_next < DEPTH.
//   An empty FIFO with no pending request never occurs without a re-issue.
//   Throughput: 1 word/cycle with an always-ready bus and consumer.
//   inst_valid = (count != 0) & !redirect_valid.
//     This is a combinational path from redirect_valid.
//   Pop: inst_valid & inst_ready.
//     Push and pop in the same cycle leave count unchanged.
//   Full (count == DEPTH): no new request is issued.
//     An already-issued request cannot exist when full, since issue requires space.
//   Redirect (priority over push/pop):
//     - count <= 0, FIFO pointers reset; any push/pop that cycle is discarded.
//     - fetch_pc <= {redirect_addr[31:2], 2'b00}.
//     - If i_valid & !i_ready: set drop=1.
//       Keep i_valid and old i_addr until the handshake.
//       On that handshake, discard i_rdata, clear drop, hold i_valid=1.
//       Move i_addr to the new fetch_pc.
//     - If i_valid & i_ready: the response is discarded.
//       Next cycle i_valid=1 at the redirect pc.
//     - If i_valid=0: next cycle i_valid=1 at the redirect pc.
//     - A redirect while drop=1 updates fetch_pc only; drop stays 1.
//   FIFO: rd/wr pointers of $clog2(DEPTH) bits wrap naturally; count tracks occupancy.
//   No combinational path from i_rdata/i_ready to i_valid/i_addr.
// TESTING
//   1. Reset, i_ready=1, inst_ready=1.
//      -> i_addr 0,4,8,... on consecutive cycles.
//      -> inst_pc/inst follow in order, one per cycle.
//   2. inst_ready=0, DEPTH=4, i_ready=1.
//      -> after 4 handshakes count=4, i_valid=0.
//      -> one pop -> i_valid=1 next cycle at addr 0x10.
//   3. i_valid high with i_ready=0 at addr 0x8, redirect to 0x103.
//      -> i_addr holds 0x8 until ready.
//      -> that word is dropped; next i_addr=0x100.
//      -> first inst_pc=0x100.
//   4. Redirect in the same cycle as an i_ready handshake at 0xC plus inst_ready.
//      -> count=0, 0xC data absent, no pop counted, next i_addr=redirect.
//   5. i_addr=0xFFFF_FFFC handshake -> next i_addr=0x0000_0000.
//   6. Reset asserted mid-stream with count=3 and i_valid=1.
//      -> same cycle: i_valid=0, inst_valid=0.
//      -> after release: i_addr=RESET_ADDR.

Source files
------------

// File: rtl/vigna_prefetch_if.sv
// Instruction prefetch bundle for the vigna core.
// Groups the i-bus request/response, the decode-side FIFO head, the redirect
// request and the occupancy count into one interface.
//   master : the prefetch unit (drives i_valid/i_addr and the FIFO head side)
//   slave  : the environment (i-bus memory, core decode stage, branch unit)
interface vigna_prefetch_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    // i-bus
    logic          i_valid;
    logic          i_ready;
    logic [31:0]   i_addr;
    logic [31:0]   i_rdata;
    // decode side
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    // redirect
    logic          redirect_valid;
    logic [31:0]   redirect_addr;
    // occupancy
    logic [CW-1:0] count;

    modport master (
        output i_valid, i_addr, inst_valid, inst, inst_pc, count,
        input  i_ready, i_rdata, inst_ready, redirect_valid, redirect_addr
    );

    modport slave (
        input  i_valid, i_addr, inst_valid, inst, inst_pc, count,
        output i_ready, i_rdata, inst_ready, redirect_valid, redirect_addr
    );
endinterface

// File: rtl/vigna_prefetch.sv
// Instruction prefetch unit for the vigna core.
// Fetches words back-to-back on the i-bus into a DEPTH-entry {pc, inst}
// FIFO whose head feeds the decode stage. A redirect flushes the FIFO and
// restarts fetching at the new pc; a request already on the bus when the
// redirect arrives is completed and its data thrown away.
// Ports:
//   clk   : clock, all state on posedge
//   reset : asynchronous active-high reset
//   bus   : vigna_prefetch_if.master (i-bus, FIFO head, redirect, count)
module vigna_prefetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic              clk,
    input  logic              reset,
    vigna_prefetch_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic          i_valid_q, i_valid_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   hold_addr_q, hold_addr_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic          handshake;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic [CW-1:0] count_next;

    assign handshake  = i_valid_q & bus.i_ready;
    assign push       = handshake & ~drop_q & ~bus.redirect_valid;
    assign head_valid = (count_q != '0) & ~bus.redirect_valid;
    assign pop        = head_valid & bus.inst_ready;
    assign count_next = count_q + CW'(push) - CW'(pop);

    // While a dropped request is still outstanding the bus must keep showing
    // its original address, even though fetch_pc already holds the redirect
    // target.
    assign bus.i_valid    = i_valid_q;
    assign bus.i_addr     = drop_q ? hold_addr_q : fetch_pc_q;
    assign bus.inst_valid = head_valid;
    assign bus.inst       = inst_mem[rd_ptr_q];
    assign bus.inst_pc    = pc_mem[rd_ptr_q];
    assign bus.count      = count_q;

    always_comb begin
        i_valid_d   = i_valid_q;
        fetch_pc_d  = fetch_pc_q;
        hold_addr_d = hold_addr_q;
        drop_d      = drop_q;
        count_d     = count_next;
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(pop);

        if (bus.redirect_valid) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = bus.redirect_addr & 32'hFFFF_FFFC;
            i_valid_d  = 1'b1;
            if (i_valid_q && !bus.i_ready) begin
                // Request stuck on the bus: finish it later and discard data.
                // A second redirect keeps the originally captured address.
                drop_d = 1'b1;
                if (!drop_q) begin
                    hold_addr_d = fetch_pc_q;
                end
            end else begin
                drop_d = 1'b0;
            end
        end else if (handshake) begin
            if (drop_q) begin
                // Stale response retired; restart at the redirect target.
                drop_d    = 1'b0;
                i_valid_d = 1'b1;
            end else begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                i_valid_d  = (count_next < CW'(DEPTH));
            end
        end else if (!i_valid_q) begin
            i_valid_d = (count_next < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_valid_q   <= 1'b0;
            fetch_pc_q  <= RESET_ADDR;
            hold_addr_q <= RESET_ADDR;
            drop_q      <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            i_valid_q   <= i_valid_d;
            fetch_pc_q  <= fetch_pc_d;
            hold_addr_q <= hold_addr_d;
            drop_q      <= drop_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // FIFO storage: contents are only meaningful below count, so no reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PW'(gi))) begin
                    pc_mem[gi]   <= fetch_pc_q;
                    inst_mem[gi] <= bus.i_rdata;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_vigna_prefetch.sv
module tb_vigna_prefetch;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vigna_prefetch_if #(.DEPTH(DEPTH)) bus ();

    vigna_prefetch #(
        .RESET_ADDR (32'h0000_0000),
        .DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int step_no = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    bit          m_valid;
    logic [31:0] m_addr;     // address currently shown on the bus
    logic [31:0] m_target;   // where fetching resumes after a dropped request
    bit          m_drop;

    // inputs currently applied to the DUT
    bit          cur_redir;
    logic [31:0] cur_raddr;
    bit          cur_iready;
    bit          cur_instrdy;
    logic [31:0] cur_rdata;

    task automatic model_reset();
        mq.delete();
        m_valid  = 0;
        m_addr   = 32'h0;
        m_target = 32'h0;
        m_drop   = 0;
    endtask

    task automatic model_update();
        bit hs;
        bit pop;
        hs  = m_valid && cur_iready;
        pop = (mq.size() != 0) && !cur_redir && cur_instrdy;
        if (cur_redir) begin
            mq.delete();
            m_target = cur_raddr & 32'hFFFF_FFFC;
            if (m_valid && !cur_iready) begin
                m_drop = 1;
            end else begin
                m_drop = 0;
                m_addr = m_target;
            end
            m_valid = 1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (hs) begin
                if (m_drop) begin
                    m_drop  = 0;
                    m_addr  = m_target;
                    m_valid = 1;
                end else begin
                    mq.push_back('{pc: m_addr, ins: cur_rdata});
                    m_addr  = m_addr + 32'd4;
                    m_valid = (mq.size() < DEPTH);
                end
            end else if (!m_valid) begin
                m_valid = (mq.size() < DEPTH);
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", nm, step_no, got, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        bit ivld;
        ivld = (mq.size() != 0) && !cur_redir;
        chk({tag, ".i_valid"}, 32'(bus.i_valid), 32'(m_valid));
        chk({tag, ".i_addr"}, bus.i_addr, m_addr);
        chk({tag, ".count"}, 32'(bus.count), 32'(mq.size()));
        chk({tag, ".inst_valid"}, 32'(bus.inst_valid), 32'(ivld));
        if (ivld) begin
            chk({tag, ".inst_pc"}, bus.inst_pc, mq[0].pc);
            chk({tag, ".inst"}, bus.inst, mq[0].ins);
        end
    endtask

    task automatic drive();
        bus.redirect_valid = cur_redir;
        bus.redirect_addr  = cur_raddr;
        bus.i_ready        = cur_iready;
        bus.inst_ready     = cur_instrdy;
        bus.i_rdata        = cur_rdata;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        cur_redir   = 0;
        cur_raddr   = 32'h0;
        cur_iready  = 0;
        cur_instrdy = 0;
        cur_rdata   = 32'h0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step_no++;
        #1 compare_all("rst");
    endtask

    // One clock: model and DUT advance on the edge with the previous inputs,
    // then the new inputs are applied at negedge and outputs checked.
    task automatic step(input bit redir, input logic [31:0] raddr,
                        input bit iready, input bit instrdy);
        @(posedge clk);
        model_update();
        @(negedge clk);
        cur_redir   = redir;
        cur_raddr   = raddr;
        cur_iready  = iready;
        cur_instrdy = instrdy;
        cur_rdata   = $urandom;
        drive();
        step_no++;
        #1 compare_all("mdl");
    endtask

    typedef struct {
        bit          iready;
        bit          instrdy;
        bit          exp_ivalid;
        logic [31:0] exp_addr;
        int          exp_count;
        bit          exp_inst_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl [9];

    initial begin
        // Fill-to-full, back-pressure release, concurrent push/pop.
        tbl[0] = '{1, 0, 1, 32'h00, 0, 0, 32'h0};
        tbl[1] = '{1, 0, 1, 32'h04, 1, 1, 32'h0};
        tbl[2] = '{1, 0, 1, 32'h08, 2, 1, 32'h0};
        tbl[3] = '{1, 0, 1, 32'h0C, 3, 1, 32'h0};
        tbl[4] = '{1, 1, 0, 32'h10, 4, 1, 32'h0};
        tbl[5] = '{1, 0, 1, 32'h10, 3, 1, 32'h4};
        tbl[6] = '{1, 1, 0, 32'h14, 4, 1, 32'h4};
        tbl[7] = '{1, 1, 1, 32'h14, 3, 1, 32'h8};
        tbl[8] = '{1, 1, 1, 32'h18, 3, 1, 32'hC};

        // Reset state
        do_reset();
        chk("reset.i_valid", 32'(bus.i_valid), 32'h0);
        chk("reset.inst_valid", 32'(bus.inst_valid), 32'h0);
        chk("reset.count", 32'(bus.count), 32'h0);

        for (int i = 0; i < 9; i++) begin
            step(0, 32'h0, tbl[i].iready, tbl[i].instrdy);
            chk($sformatf("tbl%0d.i_valid", i), 32'(bus.i_valid), 32'(tbl[i].exp_ivalid));
            chk($sformatf("tbl%0d.i_addr", i), bus.i_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d.count", i), 32'(bus.count), 32'(tbl[i].exp_count));
            chk($sformatf("tbl%0d.inst_valid", i), 32'(bus.inst_valid), 32'(tbl[i].exp_inst_valid));
            if (tbl[i].exp_inst_valid)
                chk($sformatf("tbl%0d.inst_pc", i), bus.inst_pc, tbl[i].exp_pc);
        end

        // Full-rate streaming
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step(0, 32'h0, 1, 1);
            chk($sformatf("stream%0d.i_addr", k), bus.i_addr, 32'(4 * (k - 1)));
            if (k >= 2) begin
                chk($sformatf("stream%0d.inst_pc", k), bus.inst_pc, 32'(4 * (k - 2)));
                chk($sformatf("stream%0d.count", k), 32'(bus.count), 32'd1);
            end
        end

        // Redirect while a request is stalled at 0x8
        do_reset();
        step(0, 32'h0, 1, 1);
        step(0, 32'h0, 1, 1);
        step(1, 32'h103, 0, 1);
        chk("stall.i_addr", bus.i_addr, 32'h8);
        step(0, 32'h0, 0, 1);
        chk("stall.hold_addr", bus.i_addr, 32'h8);
        chk("stall.hold_valid", 32'(bus.i_valid), 32'h1);
        step(0, 32'h0, 1, 1);
        chk("stall.drop_addr", bus.i_addr, 32'h8);
        chk("stall.drop_count", 32'(bus.count), 32'h0);
        step(0, 32'h0, 1, 1);
        chk("stall.new_addr", bus.i_addr, 32'h100);
        step(0, 32'h0, 1, 1);
        chk("stall.first_pc", bus.inst_pc, 32'h100);
        chk("stall.first_valid", 32'(bus.inst_valid), 32'h1);

        // Redirect coinciding with handshake at 0xC and inst_ready
        do_reset();
        for (int k = 0; k < 3; k++) step(0, 32'h0, 1, 0);
        step(1, 32'h200, 1, 1);
        chk("redir_hs.addr", bus.i_addr, 32'hC);
        chk("redir_hs.inst_valid", 32'(bus.inst_valid), 32'h0);
        step(0, 32'h0, 1, 0);
        chk("redir_hs.count", 32'(bus.count), 32'h0);
        chk("redir_hs.next_addr", bus.i_addr, 32'h200);
        step(0, 32'h0, 1, 0);
        chk("redir_hs.head_pc", bus.inst_pc, 32'h200);
        chk("redir_hs.count1", 32'(bus.count), 32'h1);

        // Address wrap at the top of memory
        do_reset();
        step(1, 32'hFFFF_FFFF, 1, 0);
        step(0, 32'h0, 1, 0);
        chk("wrap.top_addr", bus.i_addr, 32'hFFFF_FFFC);
        step(0, 32'h0, 1, 0);
        chk("wrap.next_addr", bus.i_addr, 32'h0);
        chk("wrap.head_pc", bus.inst_pc, 32'hFFFF_FFFC);

        // Asynchronous reset mid-stream with three entries held
        do_reset();
        for (int k = 0; k < 4; k++) step(0, 32'h0, 1, 0);
        chk("mid.count_pre", 32'(bus.count), 32'h3);
        chk("mid.valid_pre", 32'(bus.i_valid), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("mid.i_valid", 32'(bus.i_valid), 32'h0);
        chk("mid.inst_valid", 32'(bus.inst_valid), 32'h0);
        chk("mid.count", 32'(bus.count), 32'h0);
        do_reset();
        step(0, 32'h0, 1, 1);
        chk("mid.restart_addr", bus.i_addr, 32'h0);
        chk("mid.restart_valid", 32'(bus.i_valid), 32'h1);

        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 99) < 6),
                 $urandom,
                 ($urandom_range(0, 99) < 65),
                 ($urandom_range(0, 99) < 55));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
